regfile_wb_ctrl: RTL and testbench

//  Writer side of the 32x32 register file: merges ALU and LSU results onto the single
//  RD write port (rd_addr/rd_data) and keeps a pending-write scoreboard so readers of
//  RA/RB know when a register value is stale. Sits between execute/LSU and regfile.
//  rd_addr = 0 means "no write" because register r0 is never written.

---
 rtl/regfile_wb_ctrl.sv | 175 +++++++++++++++++
 tb/tb_regfile_wb_ctrl.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_ctrl.sv
// Register-file writeback controller: merges ALU and buffered LSU results onto the
// single RD write port and tracks pending writes. Optional feature: WB_FORWARD_EN.
`default_nettype none

module regfile_wb_ctrl #(
    parameter int LSU_FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        iss_valid,
    input  logic [4:0]  iss_rd,
    input  logic        alu_valid,
    input  logic [4:0]  alu_rd,
    input  logic [31:0] alu_data,
    input  logic        lsu_valid,
    output logic        lsu_ready,
    input  logic [4:0]  lsu_rd,
    input  logic [31:0] lsu_data,
    output logic [4:0]  rd_addr,
    output logic [31:0] rd_data,
    input  logic [4:0]  ra_addr,
    input  logic [4:0]  rb_addr,
    output logic        ra_busy,
    output logic        rb_busy
`ifdef WB_FORWARD_EN
    ,
    output logic        ra_fwd,
    output logic        rb_fwd
`endif
);

    localparam int AW = (LSU_FIFO_DEPTH > 1) ? $clog2(LSU_FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(LSU_FIFO_DEPTH);

    logic [4:0]    r_fifo_rd   [LSU_FIFO_DEPTH];
    logic [31:0]   r_fifo_data [LSU_FIFO_DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    logic [4:0]    r_rd_addr;
    logic [31:0]   r_rd_data;
    logic [31:0]   r_sb;

    logic          w_full;
    logic          w_empty;
    logic          w_push;
    logic          w_pop;
    logic          w_sel_valid;
    logic [4:0]    w_sel_rd;
    logic [31:0]   w_sel_data;
    logic [31:0]   w_sb_set;
    logic [31:0]   w_sb_clr;
    logic [31:0]   w_sb_next;

    // ------------------------------------------------------------------
    // LSU result buffer
    // ------------------------------------------------------------------
    assign w_full    = (r_count == FULL_COUNT);
    assign w_empty   = (r_count == '0);
    assign lsu_ready = !w_full;
    assign w_push    = lsu_valid && !w_full;
    // The ALU has no back-pressure, so the buffer only drains on ALU-idle cycles.
    assign w_pop     = !alu_valid && !w_empty;

    // NOTE: storage is not reset; only pointers/count define validity, and a
    // reset-free array maps onto plain RAM/flops without a reset tree.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_rd[r_wr_ptr]   <= lsu_rd;
            r_fifo_data[r_wr_ptr] <= lsu_data;
        end
    end

    // NOTE: all sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Writeback source selection: ALU first, then buffered LSU result
    // ------------------------------------------------------------------
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_sel_valid = 1'b0;
        w_sel_rd    = 5'd0;
        w_sel_data  = r_rd_data;
        if (alu_valid) begin
            w_sel_valid = 1'b1;
            w_sel_rd    = alu_rd;
            w_sel_data  = alu_data;
        end else if (!w_empty) begin
            w_sel_valid = 1'b1;
            w_sel_rd    = r_fifo_rd[r_rd_ptr];
            w_sel_data  = r_fifo_data[r_rd_ptr];
        end
    end

    // Idle cycles present rd_addr=0 (no write) but keep the last data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_addr <= 5'd0;
            r_rd_data <= 32'd0;
        end else begin
            r_rd_addr <= w_sel_rd;
            if (w_sel_valid) begin
                r_rd_data <= w_sel_data;
            end
        end
    end

    assign rd_addr = r_rd_addr;
    assign rd_data = r_rd_data;

    // ------------------------------------------------------------------
    // Pending-write scoreboard
    // ------------------------------------------------------------------
    always_comb begin
        w_sb_set = 32'd0;
        w_sb_clr = 32'd0;
        if (iss_valid) begin
            w_sb_set[iss_rd] = 1'b1;
        end
        // The register presented this cycle is committed by the regfile at this edge.
        w_sb_clr[r_rd_addr] = 1'b1;
        // A new issue to the same register outlives the older writeback.
        w_sb_next    = (r_sb & ~w_sb_clr) | w_sb_set;
        w_sb_next[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sb <= 32'd0;
        end else begin
            r_sb <= w_sb_next;
        end
    end

`ifdef WB_FORWARD_EN
    logic w_ra_hit;
    logic w_rb_hit;

    // The reader picks rd_data in the presenting cycle instead of stalling on it.
    assign w_ra_hit = (r_rd_addr == ra_addr) && (ra_addr != 5'd0);
    assign w_rb_hit = (r_rd_addr == rb_addr) && (rb_addr != 5'd0);
    assign ra_busy  = r_sb[ra_addr] && !w_ra_hit;
    assign rb_busy  = r_sb[rb_addr] && !w_rb_hit;
    assign ra_fwd   = w_ra_hit;
    assign rb_fwd   = w_rb_hit;
`else
    assign ra_busy  = r_sb[ra_addr];
    assign rb_busy  = r_sb[rb_addr];
`endif

endmodule

`default_nettype wire

// File: tb/tb_regfile_wb_ctrl.sv
// Directed self-checking bench for regfile_wb_ctrl (default build, LSU_FIFO_DEPTH=4).
`timescale 1ns/1ps

module tb_regfile_wb_ctrl;

    logic        clk;
    logic        rst_n;
    logic        iss_valid;
    logic [4:0]  iss_rd;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        lsu_valid;
    logic        lsu_ready;
    logic [4:0]  lsu_rd;
    logic [31:0] lsu_data;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;
    logic [4:0]  ra_addr;
    logic [4:0]  rb_addr;
    logic        ra_busy;
    logic        rb_busy;
`ifdef WB_FORWARD_EN
    logic        ra_fwd;
    logic        rb_fwd;
`endif

    int checks = 0;
    int errors = 0;

    regfile_wb_ctrl #(.LSU_FIFO_DEPTH(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .iss_valid (iss_valid),
        .iss_rd    (iss_rd),
        .alu_valid (alu_valid),
        .alu_rd    (alu_rd),
        .alu_data  (alu_data),
        .lsu_valid (lsu_valid),
        .lsu_ready (lsu_ready),
        .lsu_rd    (lsu_rd),
        .lsu_data  (lsu_data),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .ra_addr   (ra_addr),
        .rb_addr   (rb_addr),
        .ra_busy   (ra_busy),
        .rb_busy   (rb_busy)
`ifdef WB_FORWARD_EN
        ,
        .ra_fwd    (ra_fwd),
        .rb_fwd    (rb_fwd)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Advance one edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;

        rst_n     = 1'b0;
        iss_valid = 1'b0;
        iss_rd    = 5'd0;
        alu_valid = 1'b0;
        alu_rd    = 5'd0;
        alu_data  = 32'd0;
        lsu_valid = 1'b0;
        lsu_rd    = 5'd0;
        lsu_data  = 32'd0;
        ra_addr   = 5'd5;
        rb_addr   = 5'd3;

        // ---------------- reset state ----------------
        tick();
        tick();
        check("rst_rd_addr", rd_addr, 5'd0);
        check("rst_rd_data", rd_data, 32'd0);
        check("rst_lsu_ready", lsu_ready, 1'b1);
        check("rst_ra_busy", ra_busy, 1'b0);
        check("rst_rb_busy", rb_busy, 1'b0);
        rst_n = 1'b1;
        tick();

        // ---------------- ALU path ----------------
        iss_valid = 1'b1;
        iss_rd    = 5'd5;
        tick();
        iss_valid = 1'b0;
        check("alu_busy_after_iss", ra_busy, 1'b1);
        alu_valid = 1'b1;
        alu_rd    = 5'd5;
        alu_data  = 32'hDEADBEEF;
        tick();
        alu_valid = 1'b0;
        check("alu_rd_addr", rd_addr, 5'd5);
        check("alu_rd_data", rd_data, 32'hDEADBEEF);
        check("alu_busy_presenting", ra_busy, 1'b1);
        tick();
        check("alu_idle_rd_addr", rd_addr, 5'd0);
        check("alu_idle_data_held", rd_data, 32'hDEADBEEF);
        check("alu_busy_cleared", ra_busy, 1'b0);

        // ---------------- priority ----------------
        alu_valid = 1'b1;
        alu_rd    = 5'd3;
        alu_data  = 32'd1;
        lsu_valid = 1'b1;
        lsu_rd    = 5'd4;
        lsu_data  = 32'd2;
        #1;
        check("prio_lsu_ready", lsu_ready, 1'b1);
        tick();
        alu_valid = 1'b0;
        lsu_valid = 1'b0;
        check("prio_first_addr", rd_addr, 5'd3);
        check("prio_first_data", rd_data, 32'd1);
        tick();
        check("prio_second_addr", rd_addr, 5'd4);
        check("prio_second_data", rd_data, 32'd2);
        tick();
        check("prio_idle_addr", rd_addr, 5'd0);

        // ---------------- full FIFO ----------------
        n = 1;
        for (int c = 0; c < 6; c++) begin
            alu_valid = 1'b1;
            alu_rd    = 5'd10;
            alu_data  = 32'(32'hA0 + c);
            lsu_valid = 1'b1;
            lsu_rd    = 5'(n);
            lsu_data  = 32'(32'h100 + n);
            #1;
            check("full_lsu_ready", lsu_ready, (c < 4) ? 32'd1 : 32'd0);
            if (c < 4) n++;
            tick();
            check("full_alu_addr", rd_addr, 5'd10);
            check("full_alu_data", rd_data, 32'(32'hA0 + c));
        end
        alu_valid = 1'b0;
        #1;
        check("full_no_passthrough", lsu_ready, 1'b0);
        tick();
        check("drain1_addr", rd_addr, 5'd1);
        check("drain1_data", rd_data, 32'h101);
        check("drain_ready_again", lsu_ready, 1'b1);
        tick();
        lsu_valid = 1'b0;
        check("drain2_addr", rd_addr, 5'd2);
        check("drain2_data", rd_data, 32'h102);
        for (int k = 3; k <= 5; k++) begin
            tick();
            check("drain_addr", rd_addr, 32'(k));
            check("drain_data", rd_data, 32'(32'h100 + k));
        end
        tick();
        check("drain_idle_addr", rd_addr, 5'd0);
        check("drain_idle_ready", lsu_ready, 1'b1);

        // ---------------- WAW and r0 ----------------
        ra_addr   = 5'd7;
        iss_valid = 1'b1;
        iss_rd    = 5'd7;
        tick();
        iss_valid = 1'b0;
        alu_valid = 1'b1;
        alu_rd    = 5'd7;
        alu_data  = 32'h77;
        tick();
        alu_valid = 1'b0;
        check("waw_present_addr", rd_addr, 5'd7);
        iss_valid = 1'b1;
        iss_rd    = 5'd7;
        tick();
        iss_valid = 1'b0;
        check("waw_set_wins", ra_busy, 1'b1);
        tick();
        check("waw_still_busy", ra_busy, 1'b1);

        ra_addr   = 5'd0;
        iss_valid = 1'b1;
        iss_rd    = 5'd0;
        alu_valid = 1'b1;
        alu_rd    = 5'd0;
        alu_data  = 32'h55;
        tick();
        iss_valid = 1'b0;
        alu_valid = 1'b0;
        check("r0_busy", ra_busy, 1'b0);
        check("r0_rd_addr", rd_addr, 5'd0);
        check("r0_rd_data", rd_data, 32'h55);

        // ---------------- reset mid-stream ----------------
        iss_valid = 1'b1;
        iss_rd    = 5'd11;
        alu_valid = 1'b1;
        alu_rd    = 5'd20;
        alu_data  = 32'h20;
        lsu_valid = 1'b1;
        lsu_rd    = 5'd11;
        lsu_data  = 32'hB;
        tick();
        iss_valid = 1'b0;
        lsu_rd    = 5'd12;
        lsu_data  = 32'hC;
        tick();
        lsu_rd    = 5'd13;
        lsu_data  = 32'hD;
        tick();
        lsu_valid = 1'b0;
        check("mid_alu_addr", rd_addr, 5'd20);
        ra_addr = 5'd11;
        #1;
        check("mid_busy_before_rst", ra_busy, 1'b1);
        #1;
        rst_n     = 1'b0;
        alu_valid = 1'b0;
        #1;
        check("mid_rst_rd_addr", rd_addr, 5'd0);
        check("mid_rst_lsu_ready", lsu_ready, 1'b1);
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("post_rst_no_write", rd_addr, 5'd0);
        end
        for (int a = 0; a < 32; a++) begin
            ra_addr = 5'(a);
            rb_addr = 5'(a);
            #1;
            check("post_rst_ra_busy", ra_busy, 1'b0);
            check("post_rst_rb_busy", rb_busy, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
